// File: rtl/maxpool_backward.sv
// 2x2 stride-2 max-pool backward pass: streams activation and upstream gradient
// words, routes each window's gradient to its argmax position and zeroes the rest.
module maxpool_backward #(
  parameter int H      = 4,
  parameter int W      = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] g_base,
  input  logic [ADDR_W-1:0] d_base,
  output logic              done,
  output logic              busy,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [31:0]       rd_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ack
);

  localparam int IW = (H / 2 > 1) ? $clog2(H / 2) : 1;
  localparam int JW = (W / 2 > 1) ? $clog2(W / 2) : 1;
  localparam logic [IW-1:0]     I_LAST = IW'(H / 2 - 1);
  localparam logic [JW-1:0]     J_LAST = JW'(W / 2 - 1);
  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(W);
  localparam logic [ADDR_W-1:0] WH_A   = ADDR_W'(W / 2);

  typedef enum logic [2:0] {WAIT, RD_A, RD_G, WR, DONE} state_t;

  state_t            state, state_n;
  logic [1:0]        k, k_n, argmax, argmax_n;
  logic [IW-1:0]     wi, wi_n;
  logic [JW-1:0]     wj, wj_n;
  logic [ADDR_W-1:0] ab, gb, db, ab_n, gb_n, db_n;
  logic [31:0]       max_key, max_key_n, grad, grad_n, nkey;
  logic [ADDR_W-1:0] y_n, x_n, a_addr_n, g_addr_n, d_addr_n;

  // Maps fp32 bit patterns onto an unsigned total order (+0.0 above -0.0).
  function automatic logic [31:0] fkey(input logic [31:0] b);
    return b[31] ? ~b : (b | 32'h8000_0000);
  endfunction

  always_comb begin
    state_n   = state;
    k_n       = k;
    wi_n      = wi;
    wj_n      = wj;
    ab_n      = ab;
    gb_n      = gb;
    db_n      = db;
    max_key_n = max_key;
    argmax_n  = argmax;
    grad_n    = grad;
    nkey      = fkey(rd_data);
    case (state)
      WAIT: begin
        if (go) begin
          ab_n    = a_base;
          gb_n    = g_base;
          db_n    = d_base;
          wi_n    = '0;
          wj_n    = '0;
          k_n     = '0;
          state_n = RD_A;
        end
      end
      RD_A: begin
        if (rd_ack) begin
          if (k == 2'd0 || nkey > max_key) begin
            max_key_n = nkey;
            argmax_n  = k;
          end
          k_n = k + 2'd1;
          if (k == 2'd3) state_n = RD_G;
        end
      end
      RD_G: begin
        if (rd_ack) begin
          grad_n  = rd_data;
          state_n = WR;
        end
      end
      WR: begin
        if (wr_ack) begin
          k_n = k + 2'd1;
          if (k == 2'd3) begin
            if (wi == I_LAST && wj == J_LAST) begin
              state_n = DONE;
            end else begin
              state_n = RD_A;
              if (wj == J_LAST) begin
                wj_n = '0;
                wi_n = wi + IW'(1);
              end else begin
                wj_n = wj + JW'(1);
              end
            end
          end
        end
      end
      DONE: begin
        if (!go) state_n = WAIT;
      end
      default: state_n = WAIT;
    endcase

    y_n      = ADDR_W'({wi_n, k_n[1]});
    x_n      = ADDR_W'({wj_n, k_n[0]});
    a_addr_n = ab_n + y_n * W_A + x_n;
    g_addr_n = gb_n + ADDR_W'(wi_n) * WH_A + ADDR_W'(wj_n);
    d_addr_n = db_n + y_n * W_A + x_n;
  end

  // Outputs are registered from next-state values so req/addr/data hold across stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WAIT;
      k       <= '0;
      wi      <= '0;
      wj      <= '0;
      ab      <= '0;
      gb      <= '0;
      db      <= '0;
      max_key <= '0;
      argmax  <= '0;
      grad    <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      rd_req  <= 1'b0;
      rd_addr <= '0;
      wr_req  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_n;
      k       <= k_n;
      wi      <= wi_n;
      wj      <= wj_n;
      ab      <= ab_n;
      gb      <= gb_n;
      db      <= db_n;
      max_key <= max_key_n;
      argmax  <= argmax_n;
      grad    <= grad_n;
      done    <= (state_n == DONE);
      busy    <= (state_n == RD_A) || (state_n == RD_G) || (state_n == WR);
      rd_req  <= (state_n == RD_A) || (state_n == RD_G);
      rd_addr <= (state_n == RD_G) ? g_addr_n : ((state_n == RD_A) ? a_addr_n : '0);
      wr_req  <= (state_n == WR);
      wr_addr <= (state_n == WR) ? d_addr_n : '0;
      wr_data <= (state_n == WR && k_n == argmax_n) ? grad_n : '0;
    end
  end

endmodule

// File: tb/tb_maxpool_backward.sv
// Directed bench for maxpool_backward: a 2x2 instance (index 0) and a 4x4 instance (index 1).
module tb_maxpool_backward;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_en;
  logic        go      [2];
  logic        done    [2];
  logic        busy    [2];
  logic        rd_req  [2];
  logic        wr_req  [2];
  logic        rd_ack  [2];
  logic        wr_ack  [2];
  logic [31:0] rd_addr [2];
  logic [31:0] wr_addr [2];
  logic [31:0] wr_data [2];
  logic [31:0] rd_data [2];

  logic [31:0] mem   [2][64];
  logic [31:0] dx    [2][16];
  int          stamp [2][16];
  logic [31:0] exp4  [16];
  int na [2], ng [2], nw [2], viol [2];
  logic ps [2], prd [2], pwr [2];
  logic [31:0] pra [2], pwa [2], pwd [2];
  int run_id;
  int n_ass, n_fail;

  localparam logic [31:0] A4 [16] = '{
    32'h3F800000, 32'h40000000, 32'hC0000000, 32'hC0400000,
    32'h40400000, 32'h3F000000, 32'hBF800000, 32'hBF800000,
    32'h00000000, 32'h80000000, 32'h7FC00000, 32'h40000000,
    32'h80000000, 32'h00000000, 32'h41000000, 32'hFF800000};
  localparam logic [31:0] G4 [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  always #5 clk = ~clk;

  maxpool_backward #(.H(2), .W(2), .ADDR_W(32)) u_d2 (
    .clk(clk), .rst(rst), .go(go[0]),
    .a_base(32'd0), .g_base(32'd16), .d_base(32'd32),
    .done(done[0]), .busy(busy[0]),
    .rd_req(rd_req[0]), .rd_addr(rd_addr[0]), .rd_ack(rd_ack[0]), .rd_data(rd_data[0]),
    .wr_req(wr_req[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_ack(wr_ack[0]));

  maxpool_backward #(.H(4), .W(4), .ADDR_W(32)) u_d4 (
    .clk(clk), .rst(rst), .go(go[1]),
    .a_base(32'd0), .g_base(32'd16), .d_base(32'd32),
    .done(done[1]), .busy(busy[1]),
    .rd_req(rd_req[1]), .rd_addr(rd_addr[1]), .rd_ack(rd_ack[1]), .rd_data(rd_data[1]),
    .wr_req(wr_req[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_ack(wr_ack[1]));

  assign rd_data[0] = mem[0][rd_addr[0][5:0]];
  assign rd_data[1] = mem[1][rd_addr[1][5:0]];

  always @(negedge clk) begin
    rd_ack[0] = 1'b1;
    wr_ack[0] = 1'b1;
    rd_ack[1] = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    wr_ack[1] = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Bus monitor: counts beats, captures dx writes, flags unstable stalls or overlapping requests.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        ps[u] = 1'b0;
      end else begin
        if (rd_req[u] && wr_req[u]) viol[u]++;
        if (ps[u] && (rd_req[u] !== prd[u] || wr_req[u] !== pwr[u] || rd_addr[u] !== pra[u] ||
                      wr_addr[u] !== pwa[u] || wr_data[u] !== pwd[u])) viol[u]++;
        if (rd_req[u] && rd_ack[u]) begin
          if (rd_addr[u] < 32'd16) na[u]++;
          else ng[u]++;
        end
        if (wr_req[u] && wr_ack[u]) begin
          nw[u]++;
          if (wr_addr[u] < 32'd32 || wr_addr[u] > 32'd47) viol[u]++;
          dx[u][wr_addr[u][3:0]]    = wr_data[u];
          stamp[u][wr_addr[u][3:0]] = run_id;
        end
        ps[u]  = (rd_req[u] && !rd_ack[u]) || (wr_req[u] && !wr_ack[u]);
        prd[u] = rd_req[u];
        pwr[u] = wr_req[u];
        pra[u] = rd_addr[u];
        pwa[u] = wr_addr[u];
        pwd[u] = wr_data[u];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_ass++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] fkey(input logic [31:0] b);
    return b[31] ? ~b : (b | 32'h8000_0000);
  endfunction

  task automatic model4();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        int best;
        logic [31:0] bk;
        best = 0;
        bk   = '0;
        for (int k = 0; k < 4; k++) begin
          int idx;
          idx = (2 * i + k / 2) * 4 + 2 * j + k % 2;
          exp4[idx] = '0;
          if (k == 0 || fkey(mem[1][idx]) > bk) begin
            bk   = fkey(mem[1][idx]);
            best = idx;
          end
        end
        exp4[best] = mem[1][16 + i * 2 + j];
      end
  endtask

  // Called at a negedge; returns cycles from the go edge to the first cycle done is seen.
  task automatic run(input int u, input bit hold, output int cyc);
    run_id++;
    go[u] = 1'b1;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      go[u] = hold;
      cyc++;
    end while (done[u] !== 1'b1 && cyc < 3000);
    check("done_seen", 32'(done[u]), 32'd1);
  endtask

  task automatic check_dx(input int u, input int n, input string tag);
    for (int i = 0; i < n; i++)
      check(tag, (stamp[u][i] == run_id) ? dx[u][i] : 32'hDEADDEAD,
            (u == 0) ? exp4[i] : exp4[i]);
  endtask

  task automatic run2(input string tag, input logic [31:0] a [4], input logic [31:0] g,
                      input logic [31:0] e [4]);
    int cyc;
    for (int i = 0; i < 4; i++) begin
      mem[0][i] = a[i];
      exp4[i]   = e[i];
    end
    mem[0][16] = g;
    run(0, 1'b0, cyc);
    check({tag, "_latency"}, 32'(cyc), 32'd10);
    @(negedge clk);
    check({tag, "_done_fall"}, 32'(done[0]), 32'd0);
    check_dx(0, 4, {tag, "_dx"});
  endtask

  task automatic run4(input string tag, input int exp_cyc);
    int cyc, b_a, b_g, b_w, b_v;
    b_a = na[1]; b_g = ng[1]; b_w = nw[1]; b_v = viol[1];
    model4();
    run(1, 1'b0, cyc);
    if (exp_cyc > 0) check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    @(negedge clk);
    check({tag, "_done_fall"}, 32'(done[1]), 32'd0);
    check_dx(1, 16, {tag, "_dx"});
    check({tag, "_act_reads"}, 32'(na[1] - b_a), 32'd16);
    check({tag, "_grad_reads"}, 32'(ng[1] - b_g), 32'd4);
    check({tag, "_writes"}, 32'(nw[1] - b_w), 32'd16);
    check({tag, "_bus_viol"}, 32'(viol[1] - b_v), 32'd0);
  endtask

  initial begin
    int cyc, t, b_w, b_a;
    n_ass = 0; n_fail = 0; run_id = 0;
    rst = 1'b1; stall_en = 1'b0;
    go[0] = 1'b0; go[1] = 1'b0;
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 64; i++) mem[u][i] = '0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_ctrl", {28'd0, done[u], busy[u], rd_req[u], wr_req[u]}, 32'd0);
      check("rst_data", rd_addr[u] | wr_addr[u] | wr_data[u], 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    run2("basic", '{32'h3F800000, 32'h40400000, 32'h40000000, 32'hBF800000}, 32'h40A00000,
         '{32'h0, 32'h40A00000, 32'h0, 32'h0});
    run2("tie", '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000}, 32'h3F800000,
         '{32'h3F800000, 32'h0, 32'h0, 32'h0});
    run2("signed", '{32'h80000000, 32'h00000000, 32'hC0400000, 32'hBF800000}, 32'h41200000,
         '{32'h0, 32'h41200000, 32'h0, 32'h0});

    for (int i = 0; i < 16; i++) mem[1][i] = A4[i];
    for (int i = 0; i < 4; i++) mem[1][16 + i] = G4[i];
    run4("dir4", 37);

    stall_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mem[1][i] = $urandom;
      if (i > 0 && i < 16 && $urandom_range(0, 3) == 0) mem[1][i] = mem[1][i - 1];
    end
    run4("stall4", 0);
    stall_en = 1'b0;
    @(negedge clk);

    // Reset during the second write beat of window 1.
    b_w = nw[1];
    go[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go[1] = 1'b0;
    t = 0;
    while (!(nw[1] - b_w == 5 && wr_req[1] === 1'b1) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("rst_mid_found", 32'(t < 200), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_wr_req", 32'(wr_req[1]), 32'd0);
    check("rst_mid_busy", 32'(busy[1]), 32'd0);
    check("rst_mid_done", 32'(done[1]), 32'd0);
    rst = 1'b0;
    b_w = nw[1];
    repeat (6) @(negedge clk);
    check("rst_mid_no_beats", 32'(nw[1] - b_w), 32'd0);
    check("rst_mid_idle", 32'(rd_req[1] | busy[1]), 32'd0);
    run4("after_rst", 37);

    // Hold go through completion.
    run(1, 1'b1, cyc);
    b_a = na[1];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_done", 32'(done[1]), 32'd1);
      check("hold_busy", 32'(busy[1]), 32'd0);
    end
    check("hold_no_rerun", 32'(na[1] - b_a), 32'd0);
    go[1] = 1'b0;
    @(negedge clk);
    check("drop_done", 32'(done[1]), 32'd0);
    @(negedge clk);
    check("drop_idle", 32'(busy[1] | rd_req[1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_ass, n_fail);
    $finish;
  end

endmodule
